// File: rtl/generic_fifo_env_param.sv
// Single-clock parametrised FIFO with arbitrary depth, optional first-word-fall-through,
// programmable almost flags, synchronous flush, sticky error status and high-water mark.
module generic_fifo_env_param #(
   parameter int DAT_WIDTH = 36,
   parameter int DEPTH     = 16,
   parameter int FWFT      = 0,
   localparam int PTR_WIDTH = $clog2(DEPTH),
   localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clr,
   input  logic                 wr_op,
   input  logic [DAT_WIDTH-1:0] wr_data,
   input  logic                 rd_op,
   output logic [DAT_WIDTH-1:0] rd_data,
   output logic                 rd_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   input  logic [CNT_WIDTH-1:0] af_thresh,
   input  logic [CNT_WIDTH-1:0] ae_thresh,
   output logic [CNT_WIDTH-1:0] entry_used,
   output logic [CNT_WIDTH-1:0] max_used,
   output logic                 wr_full_err,
   output logic                 rd_empty_err,
   output logic [1:0]           err_sticky,
   input  logic                 stat_clr
);

   logic [DAT_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic                 wr_acc;
   logic                 rd_acc;
   logic                 wr_err_ev;
   logic                 rd_err_ev;

   // Handshake: wr_op/rd_op are single-cycle requests judged against start-of-cycle
   // full/empty; a request is either accepted that cycle or dropped with an error pulse.
   // clr swallows both requests silently.
   assign wr_acc    = wr_op & ~full & ~clr;
   assign rd_acc    = rd_op & ~empty & ~clr;
   assign wr_err_ev = wr_op & full & ~clr;
   assign rd_err_ev = rd_op & empty & ~clr;

   assign entry_used   = cnt;
   assign full         = (cnt == CNT_WIDTH'(DEPTH));
   assign empty        = (cnt == '0);
   assign almost_full  = (cnt >= af_thresh);
   assign almost_empty = (cnt <= ae_thresh);

   // Explicit wrap compare so DEPTH need not be a power of two.
   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
   endfunction

   always_comb begin
      cnt_nxt = cnt;
      if (clr)                  cnt_nxt = '0;
      else if (wr_acc & ~rd_acc) cnt_nxt = cnt + CNT_WIDTH'(1);
      else if (rd_acc & ~wr_acc) cnt_nxt = cnt - CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt          <= '0;
         max_used     <= '0;
         err_sticky   <= 2'b00;
         wr_full_err  <= 1'b0;
         rd_empty_err <= 1'b0;
      end else begin
         if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         end
         cnt          <= cnt_nxt;
         wr_full_err  <= wr_err_ev;
         rd_empty_err <= rd_err_ev;
         // A new event coinciding with stat_clr wins over the clear.
         err_sticky   <= (stat_clr ? 2'b00 : err_sticky) | {wr_err_ev, rd_err_ev};
         if (cnt_nxt > max_used) max_used <= cnt_nxt;
         else if (stat_clr)      max_used <= '0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         assign rd_data  = mem[rd_ptr];
         assign rd_valid = ~empty;
      end else begin : g_std
         logic [DAT_WIDTH-1:0] rd_data_q;
         logic                 rd_valid_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else begin
               rd_valid_q <= rd_acc;
               if (rd_acc) rd_data_q <= mem[rd_ptr];
            end
         end
         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_generic_fifo_env_param.sv
// Directed bench for generic_fifo_env_param: a standard-read and an FWFT instance share
// stimulus and are checked every cycle against a queue-based model plus literal values.
module tb_generic_fifo_env_param;
   localparam int W = 36;
   localparam int D = 6;
   localparam int CW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          reset, clr, wr_op, rd_op, stat_clr;
   logic [W-1:0]  wr_data;
   logic [CW-1:0] af_thresh, ae_thresh;

   logic [W-1:0]  s_rd_data, f_rd_data;
   logic          s_rd_valid, f_rd_valid, s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae, s_wfe, f_wfe, s_ree, f_ree;
   logic [CW-1:0] s_used, f_used, s_max, f_max;
   logic [1:0]    s_sticky, f_sticky;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   generic_fifo_env_param #(.DAT_WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
      .clk(clk), .reset(reset), .clr(clr), .wr_op(wr_op), .wr_data(wr_data),
      .rd_op(rd_op), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
      .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .entry_used(s_used),
      .max_used(s_max), .wr_full_err(s_wfe), .rd_empty_err(s_ree),
      .err_sticky(s_sticky), .stat_clr(stat_clr));

   generic_fifo_env_param #(.DAT_WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
      .clk(clk), .reset(reset), .clr(clr), .wr_op(wr_op), .wr_data(wr_data),
      .rd_op(rd_op), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
      .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh), .entry_used(f_used),
      .max_used(f_max), .wr_full_err(f_wfe), .rd_empty_err(f_ree),
      .err_sticky(f_sticky), .stat_clr(stat_clr));

   // ---------------- model ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_rd_data;
   logic         m_rd_valid, m_wfe, m_ree;
   int           m_max;
   logic [1:0]   m_sticky;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         m_rd_data  = '0;
         m_rd_valid = 1'b0;
         m_wfe      = 1'b0;
         m_ree      = 1'b0;
         m_max      = 0;
         m_sticky   = 2'b00;
      end else begin
         bit was_full, was_empty, wa, ra, we, re;
         was_full  = (exp_q.size() == D);
         was_empty = (exp_q.size() == 0);
         wa = wr_op && !clr && !was_full;
         ra = rd_op && !clr && !was_empty;
         we = wr_op && !clr && was_full;
         re = rd_op && !clr && was_empty;
         m_rd_valid = ra;
         if (ra) m_rd_data = exp_q.pop_front();
         if (wa) exp_q.push_back(wr_data);
         if (clr) exp_q.delete();
         if (exp_q.size() > m_max) m_max = exp_q.size();
         else if (stat_clr)        m_max = 0;
         if (stat_clr) m_sticky = 2'b00;
         m_sticky = m_sticky | {we, re};
         m_wfe = we;
         m_ree = re;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int n;
      #1;
      n = exp_q.size();
      chk("std entry_used", 64'(s_used), 64'(n));
      chk("std full", 64'(s_full), 64'(n == D));
      chk("std empty", 64'(s_empty), 64'(n == 0));
      chk("std almost_full", 64'(s_af), 64'(n >= int'(af_thresh)));
      chk("std almost_empty", 64'(s_ae), 64'(n <= int'(ae_thresh)));
      chk("std max_used", 64'(s_max), 64'(m_max));
      chk("std err_sticky", 64'(s_sticky), 64'(m_sticky));
      chk("std wr_full_err", 64'(s_wfe), 64'(m_wfe));
      chk("std rd_empty_err", 64'(s_ree), 64'(m_ree));
      chk("std rd_valid", 64'(s_rd_valid), 64'(m_rd_valid));
      chk("std rd_data", 64'(s_rd_data), 64'(m_rd_data));
      chk("fwft entry_used", 64'(f_used), 64'(n));
      chk("fwft max_used", 64'(f_max), 64'(m_max));
      chk("fwft err_sticky", 64'(f_sticky), 64'(m_sticky));
      chk("fwft errs", 64'({f_wfe, f_ree}), 64'({m_wfe, m_ree}));
      chk("fwft rd_valid", 64'(f_rd_valid), 64'(n != 0));
      if (n != 0) chk("fwft rd_data", 64'(f_rd_data), 64'(exp_q[0]));
   end

   // ---------------- driver ----------------
   task automatic step(input logic w, input logic [W-1:0] d, input logic r);
      wr_op   = w;
      wr_data = d;
      rd_op   = r;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; clr = 1'b0; wr_op = 1'b0; rd_op = 1'b0; stat_clr = 1'b0;
      wr_data = '0; af_thresh = CW'(4); ae_thresh = CW'(1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset entry_used", 64'(s_used), 64'd0);
      chk("reset empty", 64'(s_empty), 64'd1);
      chk("reset rd_valid", 64'(s_rd_valid), 64'd0);
      chk("reset rd_data", 64'(s_rd_data), 64'd0);

      // fill with 1..6, watching the threshold flags
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, W'(i), 1'b0);
         chk("fill almost_empty", 64'(s_ae), 64'(i <= 1));
         chk("fill almost_full", 64'(s_af), 64'(i >= 4));
      end
      chk("fill full", 64'(s_full), 64'd1);
      chk("fill entry_used", 64'(s_used), 64'd6);
      chk("fill max_used", 64'(s_max), 64'd6);

      // overflow
      step(1'b1, W'(7), 1'b0);
      chk("ovf pulse", 64'(s_wfe), 64'd1);
      chk("ovf sticky", 64'(s_sticky), 64'd2);
      step(1'b0, '0, 1'b0);
      chk("ovf pulse end", 64'(s_wfe), 64'd0);

      // drain, data order 1..6
      for (int i = 1; i <= 6; i++) begin
         chk("drain fwft head", 64'(f_rd_data), 64'(i));
         step(1'b0, '0, 1'b1);
         chk("drain rd_valid", 64'(s_rd_valid), 64'd1);
         chk("drain rd_data", 64'(s_rd_data), 64'(i));
      end
      chk("drain empty", 64'(s_empty), 64'd1);
      step(1'b0, '0, 1'b0);
      chk("idle rd_valid", 64'(s_rd_valid), 64'd0);
      chk("idle rd_data hold", 64'(s_rd_data), 64'd6);

      // underflow then stat_clr
      step(1'b0, '0, 1'b1);
      chk("unf pulse", 64'(s_ree), 64'd1);
      chk("unf sticky", 64'(s_sticky), 64'd3);
      stat_clr = 1'b1;
      step(1'b0, '0, 1'b0);
      stat_clr = 1'b0;
      chk("stat_clr sticky", 64'(s_sticky), 64'd0);
      chk("stat_clr max", 64'(s_max), 64'd0);

      // hold three entries, then simultaneous read+write across the wrap
      for (int i = 0; i < 3; i++) step(1'b1, W'(36'h10 + i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, W'(36'h20 + i), 1'b1);
         chk("wrap entry_used", 64'(s_used), 64'd3);
         chk("wrap rd_data", 64'(s_rd_data), (i < 3) ? 64'(36'h10 + i) : 64'(36'h20 + i - 3));
      end

      // fill to full, then simultaneous rd+wr while full
      for (int i = 0; i < 3; i++) step(1'b1, W'(36'h30 + i), 1'b0);
      chk("full again", 64'(s_full), 64'd1);
      step(1'b1, W'(36'h99), 1'b1);
      chk("full rw rd_data", 64'(s_rd_data), 64'h27);
      chk("full rw err", 64'(s_wfe), 64'd1);
      chk("full rw entry_used", 64'(s_used), 64'd5);

      // flush with four entries and a concurrent write
      step(1'b0, '0, 1'b1);
      chk("pre clr entry_used", 64'(s_used), 64'd4);
      clr = 1'b1;
      step(1'b1, W'(36'h55), 1'b1);
      clr = 1'b0;
      chk("clr entry_used", 64'(s_used), 64'd0);
      chk("clr no wr err", 64'(s_wfe), 64'd0);
      chk("clr no rd err", 64'(s_ree), 64'd0);
      chk("clr max kept", 64'(s_max), 64'd6);
      chk("clr rd_valid", 64'(s_rd_valid), 64'd0);

      // FWFT visibility and pop
      step(1'b1, 36'hA5A5A5A5A, 1'b0);
      chk("fwft valid", 64'(f_rd_valid), 64'd1);
      chk("fwft data", 64'(f_rd_data), 64'hA5A5A5A5A);
      step(1'b0, '0, 1'b1);
      chk("fwft pop empty", 64'(f_empty), 64'd1);
      chk("fwft pop valid", 64'(f_rd_valid), 64'd0);
      chk("std pop data", 64'(s_rd_data), 64'hA5A5A5A5A);

      // threshold extremes
      af_thresh = '0; ae_thresh = CW'(6);
      step(1'b1, W'(36'h1), 1'b0);
      chk("af zero", 64'(s_af), 64'd1);
      chk("ae depth", 64'(s_ae), 64'd1);
      af_thresh = CW'(4); ae_thresh = CW'(1);

      // async reset asserted mid-read
      step(1'b1, W'(36'h2), 1'b0);
      rd_op = 1'b1;
      wr_op = 1'b0;
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("areset entry_used", 64'(s_used), 64'd0);
      chk("areset rd_valid", 64'(s_rd_valid), 64'd0);
      chk("areset rd_data", 64'(s_rd_data), 64'd0);
      chk("areset max", 64'(s_max), 64'd0);
      chk("areset empty", 64'(f_empty), 64'd1);
      rd_op = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      step(1'b0, '0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
